writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, with ports as listed below.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low; asserted at 0.
REQ-004 MEMWB_ready  in  1  upstream entry valid this cycle.
REQ-005 memwb_aluresult  in  64  ALU result for non-load entries.
REQ-006 memwb_loadeddata  in  64  aligned doubleword read by the memory stage.
REQ-007 memwb_rd  in  6  rd[4:0] is the register index; rd[5]=1 means no destination.
REQ-008 memwb_is_load  in  1  entry takes its data from memwb_loadeddata.
REQ-009 memwb_funct3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 treated as LD.
REQ-010 memwb_addr_lo  in  3  byte offset of the load within the doubleword.
REQ-011 wb_stall  out  1  upstream SHALL hold its entry while this is 1.
REQ-012 wb_we  out  1  register-file write request.
REQ-013 wb_rd  out  5  write index.
REQ-014 wb_data  out  64  write data.
REQ-015 regfile_grant  in  1  register file accepts the wb_we request this cycle.
REQ-016 fwd_query_rd  in  5  bypass lookup index.
REQ-017 fwd_hit  out  1  a pending entry matches fwd_query_rd.
REQ-018 fwd_data  out  64  data of the youngest matching pending entry.
REQ-019 misalign_err  out  1  one-cycle pulse flagging a misaligned load.
REQ-020 instret  out  64  retired-entry count (present only with the macro; see Configuration).

Function
REQ-021 Pending entries SHALL be held in a 2-entry FIFO of {rd[4:0], data[63:0]}; count is 0..2.
REQ-022 wb_stall SHALL equal (count==2), decoded from registers only, not combinationally from inputs.
REQ-023 An entry SHALL be accepted at the rising edge when MEMWB_ready=1 and wb_stall=0; otherwise the inputs are ignored.
REQ-024 Load data SHALL be shifted right by 8*memwb_addr_lo, then truncated to the funct3 size and sign- or zero-extended to 64 bits before enqueue.
REQ-025 A load is misaligned when LH/LHU has addr_lo[0]=1, LW/LWU has addr_lo[1:0]!=0, or LD has addr_lo!=0.
REQ-026 A misaligned load SHALL be accepted but not enqueued, and misalign_err SHALL pulse high in the following cycle.
REQ-027 An accepted entry with rd[5]=1 or rd[4:0]=0 SHALL be retired without being enqueued.
REQ-028 An entry accepted at edge N with an empty FIFO SHALL drive wb_we=1 in cycle N+1, giving a latency of 1 cycle.
REQ-029 wb_we SHALL equal (count>0); wb_rd and wb_data SHALL come from the FIFO head.
REQ-030 The head SHALL pop at an edge where wb_we=1 and regfile_grant=1; while grant=0 the head SHALL stay stable.
REQ-031 Push and pop at the same edge SHALL leave count unchanged and preserve FIFO order.
REQ-032 When count==2, a pop SHALL clear wb_stall in the next cycle; no push SHALL occur at that same edge.
REQ-033 fwd_hit and fwd_data SHALL be combinational over the FIFO contents; if both entries match, the younger entry wins.
REQ-034 fwd_query_rd=0 SHALL always return fwd_hit=0.

Reset
REQ-035 While reset=0, count SHALL be 0, FIFO storage SHALL be 0, wb_we/wb_stall/fwd_hit/misalign_err SHALL be 0, wb_rd/wb_data/fwd_data SHALL be 0, and instret SHALL be 0.
REQ-036 Reset asserted mid-operation SHALL discard pending entries immediately, without waiting for a clock edge.
REQ-037 After deassertion, the first acceptance SHALL be possible at the next rising edge.

Configuration
REQ-038 Macro WB_INSTRET_EN defined: instret SHALL increment by 1 for each pop, each rd-less or x0 retire, and each misaligned acceptance.
REQ-039 If a retire event and a pop coincide at one edge, instret SHALL add 2.
REQ-040 instret SHALL wrap from 2^64-1 to 0.
REQ-041 Macro WB_INSTRET_EN undefined: the instret port and its counter SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-042 Load with loadeddata=0x8899AABBCCDDEEFF, funct3=000, addr_lo=1, rd=5, grant=1 -> next cycle wb_we=1, wb_rd=5, wb_data=0xFFFFFFFFFFFFFFEE.
REQ-043 Same data with funct3=101, addr_lo=2 -> wb_data=0x000000000000CCDD.
REQ-044 grant held 0 while ALU entries rd=3 (data 0x11) then rd=3 (data 0x22) are accepted -> wb_stall=1, fwd_query_rd=3 gives hit with 0x22; after grant=1, writes occur in order 0x11 then 0x22.
REQ-045 LW with addr_lo=2 -> no write, misalign_err=1 for exactly one cycle, instret +1.
REQ-046 Reset pulled low while count=2 -> wb_we=0 and count=0 immediately; instret=0.
REQ-047 ALU entry with rd=0 and one with rd[5]=1 -> no wb_we; instret +2.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: load alignment/extension, 2-entry pending-write FIFO, bypass lookup.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module writeback_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEMWB_ready,
  input  logic [63:0] memwb_aluresult,
  input  logic [63:0] memwb_loadeddata,
  input  logic [5:0]  memwb_rd,
  input  logic        memwb_is_load,
  input  logic [2:0]  memwb_funct3,
  input  logic [2:0]  memwb_addr_lo,
  output logic        wb_stall,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  input  logic        regfile_grant,
  input  logic [4:0]  fwd_query_rd,
  output logic        fwd_hit,
  output logic [63:0] fwd_data,
  output logic        misalign_err
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } entry_t;

  // slot0 is always the head; slot1 holds the younger entry when count==2.
  entry_t      slot0, slot1;
  logic [1:0]  count;

  logic        accept, misalign, no_dest, push, pop, retire;
  logic [63:0] shifted, load_value;
  entry_t      new_entry;

  assign wb_stall = (count == 2'd2);
  assign wb_we    = (count != 2'd0);
  assign wb_rd    = slot0.rd;
  assign wb_data  = slot0.data;

  assign accept  = MEMWB_ready & ~wb_stall;
  assign no_dest = memwb_rd[5] | (memwb_rd[4:0] == 5'd0);
  assign push    = accept & ~misalign & ~no_dest;
  assign pop     = wb_we & regfile_grant;
  assign retire  = accept & (misalign | no_dest);

  always_comb begin
    shifted = memwb_loadeddata >> {memwb_addr_lo, 3'b000};
    case (memwb_funct3)
      3'b000:  load_value = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_value = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_value = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  load_value = {56'd0, shifted[7:0]};
      3'b101:  load_value = {48'd0, shifted[15:0]};
      3'b110:  load_value = {32'd0, shifted[31:0]};
      default: load_value = shifted;
    endcase
  end

  always_comb begin
    misalign = 1'b0;
    if (memwb_is_load) begin
      case (memwb_funct3)
        3'b001, 3'b101: misalign = memwb_addr_lo[0];
        3'b010, 3'b110: misalign = |memwb_addr_lo[1:0];
        3'b011, 3'b111: misalign = |memwb_addr_lo;
        default:        misalign = 1'b0;
      endcase
    end
  end

  assign new_entry.rd   = memwb_rd[4:0];
  assign new_entry.data = memwb_is_load ? load_value : memwb_aluresult;

  // NOTE: FIFO storage is reset too, so wb_rd/wb_data/fwd_data read 0 while empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count        <= 2'd0;
      slot0        <= '0;
      slot1        <= '0;
      misalign_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      misalign_err <= accept & misalign;
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= new_entry;
          else               slot1 <= new_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          slot1 <= '0;
          count <= count - 2'd1;
        end
        // Push implies count<=1, so a simultaneous pop leaves only the new entry.
        2'b11: slot0 <= new_entry;
        default: ;
      endcase
    end
  end

  // Younger entry (slot1) takes priority over the head.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_query_rd != 5'd0) begin
      if (count == 2'd2 && slot1.rd == fwd_query_rd) begin
        fwd_hit  = 1'b1;
        fwd_data = slot1.data;
      end else if (count != 2'd0 && slot0.rd == fwd_query_rd) begin
        fwd_hit  = 1'b1;
        fwd_data = slot0.data;
      end
    end
  end

`ifdef WB_INSTRET_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) instret <= '0;
    else        instret <= instret + {63'd0, pop} + {63'd0, retire};
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        MEMWB_ready;
  logic [63:0] memwb_aluresult;
  logic [63:0] memwb_loadeddata;
  logic [5:0]  memwb_rd;
  logic        memwb_is_load;
  logic [2:0]  memwb_funct3;
  logic [2:0]  memwb_addr_lo;
  logic        wb_stall;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        regfile_grant;
  logic [4:0]  fwd_query_rd;
  logic        fwd_hit;
  logic [63:0] fwd_data;
  logic        misalign_err;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
  logic [63:0] exp_instret;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] LD_WORD = 64'h8899AABBCCDDEEFF;

  writeback_stage dut (
    .clk              (clk),
    .reset            (reset),
    .MEMWB_ready      (MEMWB_ready),
    .memwb_aluresult  (memwb_aluresult),
    .memwb_loadeddata (memwb_loadeddata),
    .memwb_rd         (memwb_rd),
    .memwb_is_load    (memwb_is_load),
    .memwb_funct3     (memwb_funct3),
    .memwb_addr_lo    (memwb_addr_lo),
    .wb_stall         (wb_stall),
    .wb_we            (wb_we),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .regfile_grant    (regfile_grant),
    .fwd_query_rd     (fwd_query_rd),
    .fwd_hit          (fwd_hit),
    .fwd_data         (fwd_data),
    .misalign_err     (misalign_err)
`ifdef WB_INSTRET_EN
    ,
    .instret          (instret)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [2:0] f3, input logic [2:0] lo, input logic [5:0] rd);
    MEMWB_ready      = 1'b1;
    memwb_is_load    = 1'b1;
    memwb_loadeddata = LD_WORD;
    memwb_funct3     = f3;
    memwb_addr_lo    = lo;
    memwb_rd         = rd;
  endtask

  task automatic set_alu(input logic [63:0] value, input logic [5:0] rd);
    MEMWB_ready     = 1'b1;
    memwb_is_load   = 1'b0;
    memwb_aluresult = value;
    memwb_rd        = rd;
    memwb_funct3    = 3'b000;
    memwb_addr_lo   = 3'b000;
  endtask

  initial begin
    reset            = 1'b0;
    MEMWB_ready      = 1'b0;
    memwb_aluresult  = '0;
    memwb_loadeddata = '0;
    memwb_rd         = '0;
    memwb_is_load    = 1'b0;
    memwb_funct3     = '0;
    memwb_addr_lo    = '0;
    regfile_grant    = 1'b1;
    fwd_query_rd     = 5'd3;
`ifdef WB_INSTRET_EN
    exp_instret      = '0;
`endif

    #2;
    check("rst_we",       {63'd0, wb_we},        64'd0);
    check("rst_stall",    {63'd0, wb_stall},     64'd0);
    check("rst_rd",       {59'd0, wb_rd},        64'd0);
    check("rst_data",     wb_data,               64'd0);
    check("rst_fwd_hit",  {63'd0, fwd_hit},      64'd0);
    check("rst_fwd_data", fwd_data,              64'd0);
    check("rst_misalign", {63'd0, misalign_err}, 64'd0);
`ifdef WB_INSTRET_EN
    check("rst_instret",  instret,               64'd0);
`endif
    tick();
    reset = 1'b1;

    // LB, offset 1 -> 0xEE sign-extended
    set_load(3'b000, 3'd1, 6'd5);
    tick();
    check("lb_we",   {63'd0, wb_we}, 64'd1);
    check("lb_rd",   {59'd0, wb_rd}, 64'd5);
    check("lb_data", wb_data,        64'hFFFFFFFFFFFFFFEE);
    // LHU, offset 2 -> 0xCCDD; LB pops at the same edge
    set_load(3'b101, 3'd2, 6'd6);
    tick();
    check("lhu_rd",   {59'd0, wb_rd}, 64'd6);
    check("lhu_data", wb_data,        64'h000000000000CCDD);
    set_load(3'b010, 3'd4, 6'd10);
    tick();
    check("lw_data", wb_data, 64'hFFFFFFFF8899AABB);
    set_load(3'b100, 3'd7, 6'd11);
    tick();
    check("lbu_data", wb_data, 64'h0000000000000088);
    set_load(3'b011, 3'd0, 6'd12);
    tick();
    check("ld_data", wb_data, LD_WORD);
    MEMWB_ready = 1'b0;
    tick();
    check("drain_we", {63'd0, wb_we}, 64'd0);
`ifdef WB_INSTRET_EN
    exp_instret = 64'd5;
    check("instret_loads", instret, exp_instret);
`endif

    // Two rd=3 entries with grant held low
    regfile_grant = 1'b0;
    set_alu(64'h11, 6'd3);
    tick();
    check("fill1_stall", {63'd0, wb_stall}, 64'd0);
    check("fill1_data",  wb_data,           64'h11);
    set_alu(64'h22, 6'd3);
    tick();
    set_alu(64'h33, 6'd7);
    fwd_query_rd = 5'd3;
    #1;
    check("full_stall",    {63'd0, wb_stall}, 64'd1);
    check("fwd_young_hit", {63'd0, fwd_hit},  64'd1);
    check("fwd_young",     fwd_data,          64'h22);
    fwd_query_rd = 5'd0;
    #1;
    check("fwd_x0_hit", {63'd0, fwd_hit}, 64'd0);
    fwd_query_rd = 5'd5;
    #1;
    check("fwd_miss_hit",  {63'd0, fwd_hit}, 64'd0);
    check("fwd_miss_data", fwd_data,         64'd0);
    tick();
    check("hold_stall", {63'd0, wb_stall}, 64'd1);
    check("hold_rd",    {59'd0, wb_rd},    64'd3);
    check("hold_data",  wb_data,           64'h11);
    regfile_grant = 1'b1;
    tick();
    MEMWB_ready  = 1'b0;
    fwd_query_rd = 5'd3;
    #1;
    check("pop1_stall", {63'd0, wb_stall}, 64'd0);
    check("pop1_we",    {63'd0, wb_we},    64'd1);
    check("pop1_data",  wb_data,           64'h22);
    check("pop1_fwd",   fwd_data,          64'h22);
    tick();
    check("pop2_we", {63'd0, wb_we}, 64'd0);
`ifdef WB_INSTRET_EN
    exp_instret += 64'd2;
    check("instret_pops", instret, exp_instret);
`endif

    // Misaligned LW
    set_load(3'b010, 3'd2, 6'd9);
    tick();
    MEMWB_ready = 1'b0;
    check("mis_lw_we",  {63'd0, wb_we},        64'd0);
    check("mis_lw_err", {63'd0, misalign_err}, 64'd1);
    tick();
    check("mis_lw_err_end", {63'd0, misalign_err}, 64'd0);
`ifdef WB_INSTRET_EN
    exp_instret += 64'd1;
    check("instret_mis", instret, exp_instret);
`endif
    set_load(3'b101, 3'd1, 6'd9);
    tick();
    MEMWB_ready = 1'b0;
    check("mis_lhu_err", {63'd0, misalign_err}, 64'd1);
    check("mis_lhu_we",  {63'd0, wb_we},        64'd0);
    tick();
    check("mis_lhu_err_end", {63'd0, misalign_err}, 64'd0);

    // rd=x0 and rd-less entries retire without writing
    set_alu(64'h99, 6'd0);
    tick();
    check("x0_we", {63'd0, wb_we}, 64'd0);
    set_alu(64'h98, 6'h25);
    tick();
    MEMWB_ready = 1'b0;
    check("nodest_we", {63'd0, wb_we}, 64'd0);
`ifdef WB_INSTRET_EN
    exp_instret += 64'd3;
    check("instret_retire", instret, exp_instret);
`endif

    // Asynchronous reset with a full FIFO
    regfile_grant = 1'b0;
    set_alu(64'h44, 6'd3);
    tick();
    set_alu(64'h55, 6'd4);
    tick();
    MEMWB_ready = 1'b0;
    check("pre_rst_stall", {63'd0, wb_stall}, 64'd1);
    #2;
    reset        = 1'b0;
    fwd_query_rd = 5'd4;
    #1;
    check("arst_we",    {63'd0, wb_we},    64'd0);
    check("arst_stall", {63'd0, wb_stall}, 64'd0);
    check("arst_data",  wb_data,           64'd0);
    check("arst_fwd",   {63'd0, fwd_hit},  64'd0);
`ifdef WB_INSTRET_EN
    exp_instret = 64'd0;
    check("arst_instret", instret, exp_instret);
`endif
    tick();
    reset         = 1'b1;
    regfile_grant = 1'b1;
    set_alu(64'h66, 6'd8);
    tick();
    MEMWB_ready = 1'b0;
    check("post_rst_we",   {63'd0, wb_we}, 64'd1);
    check("post_rst_rd",   {59'd0, wb_rd}, 64'd8);
    check("post_rst_data", wb_data,        64'h66);
    tick();
    check("post_rst_drain", {63'd0, wb_we}, 64'd0);
`ifdef WB_INSTRET_EN
    exp_instret += 64'd1;
    check("instret_final", instret, exp_instret);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
